// File: rtl/display_pkg.sv
// Shared control codes, printable bounds and FSM/cursor encodings
// for the display text buffer.
package display_pkg;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {IDLE, SCROLL, CLEAR} disp_state_t;

  typedef enum logic [2:0] {
    CUR_HOLD,
    CUR_ADV,
    CUR_NEXT_LINE,
    CUR_RETREAT,
    CUR_HOME,
    CUR_LAST_ROW
  } cursor_op_t;

  // A single-row grid still needs a one-bit row field.
  function automatic int row_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/display_text_buffer_if.sv
// Request and grid bundle between the message source and the text buffer.
interface display_text_buffer_if #(
  parameter int ROWS   = 2,
  parameter int COLS   = 16,
  parameter int CHAR_W = 8
);
  localparam int RW = display_pkg::row_w(ROWS);
  localparam int CW = $clog2(COLS);

  logic                        ready;
  logic [CHAR_W-1:0]           msg;
  logic [ROWS*COLS*CHAR_W-1:0] rows;
  logic [RW-1:0]               cur_row;
  logic [CW-1:0]               cur_col;
  logic                        busy;
  logic                        update;
  logic                        drop;

  modport master (
    output ready, msg,
    input  rows, cur_row, cur_col, busy, update, drop
  );

  modport slave (
    input  ready, msg,
    output rows, cur_row, cur_col, busy, update, drop
  );
endinterface

// File: rtl/display_cursor.sv
// Cursor register with advance/wrap/retreat and position flags.
module display_cursor
  import display_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 16,
  localparam int RW  = row_w(ROWS),
  localparam int CW  = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          nRst,
  input  cursor_op_t    op,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic [RW-1:0] prev_row,
  output logic [CW-1:0] prev_col,
  output logic          at_last_row,
  output logic          at_last_cell,
  output logic          at_origin
);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  logic [RW-1:0] row_reg;
  logic [CW-1:0] col_reg;
  logic          at_last_col;

  assign at_last_col  = (col_reg == LAST_COL);
  assign at_last_row  = (row_reg == LAST_ROW);
  assign at_last_cell = at_last_row && at_last_col;
  assign at_origin    = (row_reg == '0) && (col_reg == '0);

  // Cell just before the cursor; meaningless at the origin, where it is never used.
  always_comb begin
    prev_row = row_reg;
    prev_col = col_reg - CW'(1);
    if (col_reg == '0) begin
      prev_row = row_reg - RW'(1);
      prev_col = LAST_COL;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      row_reg <= '0;
      col_reg <= '0;
    end else begin
      case (op)
        CUR_ADV: begin
          if (!at_last_col) begin
            col_reg <= col_reg + CW'(1);
          end else if (!at_last_row) begin
            row_reg <= row_reg + RW'(1);
            col_reg <= '0;
          end
        end
        CUR_NEXT_LINE: begin
          row_reg <= row_reg + RW'(1);
          col_reg <= '0;
        end
        CUR_RETREAT: begin
          row_reg <= prev_row;
          col_reg <= prev_col;
        end
        CUR_HOME: begin
          row_reg <= '0;
          col_reg <= '0;
        end
        CUR_LAST_ROW: begin
          row_reg <= LAST_ROW;
          col_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  assign row = row_reg;
  assign col = col_reg;
endmodule

// File: rtl/display_text_buffer.sv
// ROWS x COLS character grid for the LCD driver: typed characters, newline,
// backspace, column-by-column clear and scroll-up when the grid is full.
module display_text_buffer
  import display_pkg::*;
#(
  parameter int                ROWS   = 2,
  parameter int                COLS   = 16,
  parameter int                CHAR_W = 8,
  parameter logic [CHAR_W-1:0] BLANK  = CHAR_W'(8'h20)
) (
  input logic                   clk,
  input logic                   nRst,
  display_text_buffer_if.slave  bus
);
  localparam int RW = row_w(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  disp_state_t       state_reg;
  logic [CW-1:0]     clr_col_reg;
  logic              busy_reg;
  logic              update_reg;
  logic              drop_reg;
  logic [CHAR_W-1:0] grid_reg [ROWS][COLS];

  cursor_op_t    cur_op;
  logic [RW-1:0] cur_row, prev_row;
  logic [CW-1:0] cur_col, prev_col;
  logic          at_last_row, at_last_cell, at_origin;
  logic          is_print, is_lf, is_bs, is_ff;

  assign is_print = (bus.msg >= CHAR_W'(PRINT_LO)) && (bus.msg <= CHAR_W'(PRINT_HI));
  assign is_lf    = (bus.msg == CHAR_W'(CH_LF));
  assign is_bs    = (bus.msg == CHAR_W'(CH_BS));
  assign is_ff    = (bus.msg == CHAR_W'(CH_FF));

  display_cursor #(.ROWS(ROWS), .COLS(COLS)) u_cursor (
    .clk          (clk),
    .nRst         (nRst),
    .op           (cur_op),
    .row          (cur_row),
    .col          (cur_col),
    .prev_row     (prev_row),
    .prev_col     (prev_col),
    .at_last_row  (at_last_row),
    .at_last_cell (at_last_cell),
    .at_origin    (at_origin)
  );

  always_comb begin
    cur_op = CUR_HOLD;
    case (state_reg)
      IDLE: begin
        if (bus.ready) begin
          if (is_print)                  cur_op = CUR_ADV;
          else if (is_lf && !at_last_row) cur_op = CUR_NEXT_LINE;
          else if (is_bs && !at_origin)   cur_op = CUR_RETREAT;
        end
      end
      SCROLL:  cur_op = CUR_LAST_ROW;
      CLEAR:   if (clr_col_reg == LAST_COL) cur_op = CUR_HOME;
      default: cur_op = CUR_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_reg   <= IDLE;
      clr_col_reg <= '0;
      busy_reg    <= 1'b0;
      update_reg  <= 1'b0;
      drop_reg    <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          grid_reg[r][c] <= BLANK;
    end else begin
      update_reg <= 1'b0;
      drop_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.ready) begin
            if (is_print) begin
              // The last-cell write lands here, then scrolls up with the rest of the row.
              grid_reg[cur_row][cur_col] <= bus.msg;
              update_reg <= 1'b1;
              if (at_last_cell) begin
                state_reg <= SCROLL;
                busy_reg  <= 1'b1;
              end
            end else if (is_lf) begin
              if (at_last_row) begin
                state_reg <= SCROLL;
                busy_reg  <= 1'b1;
              end else begin
                update_reg <= 1'b1;
              end
            end else if (is_bs) begin
              if (!at_origin) begin
                grid_reg[prev_row][prev_col] <= BLANK;
                update_reg <= 1'b1;
              end
            end else if (is_ff) begin
              state_reg   <= CLEAR;
              busy_reg    <= 1'b1;
              clr_col_reg <= '0;
            end
          end
        end
        SCROLL: begin
          for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++)
              grid_reg[r][c] <= grid_reg[r+1][c];
          for (int c = 0; c < COLS; c++)
            grid_reg[ROWS-1][c] <= BLANK;
          update_reg <= 1'b1;
          drop_reg   <= bus.ready;
          state_reg  <= IDLE;
          busy_reg   <= 1'b0;
        end
        CLEAR: begin
          for (int r = 0; r < ROWS; r++)
            grid_reg[r][clr_col_reg] <= BLANK;
          drop_reg <= bus.ready;
          if (clr_col_reg == LAST_COL) begin
            update_reg <= 1'b1;
            state_reg  <= IDLE;
            busy_reg   <= 1'b0;
          end else begin
            clr_col_reg <= clr_col_reg + CW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Row 0, column 0 sits in the most significant character slot.
  generate
    for (genvar gi = 0; gi < ROWS * COLS; gi++) begin : g_pack
      assign bus.rows[(ROWS*COLS-gi)*CHAR_W-1 -: CHAR_W] = grid_reg[gi/COLS][gi%COLS];
    end
  endgenerate

  assign bus.cur_row = cur_row;
  assign bus.cur_col = cur_col;
  assign bus.busy    = busy_reg;
  assign bus.update  = update_reg;
  assign bus.drop    = drop_reg;
endmodule

// File: tb/tb_display_text_buffer.sv
// Bench for display_text_buffer: a 2x16 and a 4x20 instance driven with directed
// and random requests, checked against a character-array model of the grid.
module tb_display_text_buffer;
  logic clk  = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  display_text_buffer_if #(.ROWS(2), .COLS(16), .CHAR_W(8)) if0 ();
  display_text_buffer_if #(.ROWS(4), .COLS(20), .CHAR_W(8)) if1 ();

  display_text_buffer #(.ROWS(2), .COLS(16), .CHAR_W(8), .BLANK(8'h20)) dut0 (
    .clk(clk), .nRst(nRst), .bus(if0.slave));
  display_text_buffer #(.ROWS(4), .COLS(20), .CHAR_W(8), .BLANK(8'h20)) dut1 (
    .clk(clk), .nRst(nRst), .bus(if1.slave));

  int n_cmp = 0;
  int n_bad = 0;

  int R[2] = '{2, 4};
  int C[2] = '{16, 20};
  byte unsigned mg[2][4][20];
  int mr[2];
  int mc[2];

  logic [639:0] o_rows;
  int           o_row, o_col;
  logic         o_busy, o_upd, o_drop;

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic rdy, input logic [7:0] m);
    if (d == 0) begin if0.ready = rdy; if0.msg = m; end
    else        begin if1.ready = rdy; if1.msg = m; end
  endtask

  task automatic sample(input int d);
    if (d == 0) begin
      o_rows = 640'(if0.rows); o_row = int'(if0.cur_row); o_col = int'(if0.cur_col);
      o_busy = if0.busy; o_upd = if0.update; o_drop = if0.drop;
    end else begin
      o_rows = 640'(if1.rows); o_row = int'(if1.cur_row); o_col = int'(if1.cur_col);
      o_busy = if1.busy; o_upd = if1.update; o_drop = if1.drop;
    end
  endtask

  task automatic model_clear(input int d);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 20; c++)
        mg[d][r][c] = 8'h20;
    mr[d] = 0;
    mc[d] = 0;
  endtask

  task automatic model_scroll(input int d);
    for (int r = 0; r < R[d] - 1; r++)
      for (int c = 0; c < C[d]; c++)
        mg[d][r][c] = mg[d][r+1][c];
    for (int c = 0; c < C[d]; c++)
      mg[d][R[d]-1][c] = 8'h20;
    mr[d] = R[d] - 1;
    mc[d] = 0;
  endtask

  // nxt: 0 = stays idle, 1 = scroll follows, 2 = clear follows
  task automatic model_apply(input int d, input logic [7:0] ch, output int upd, output int nxt);
    upd = 0;
    nxt = 0;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      mg[d][mr[d]][mc[d]] = ch;
      upd = 1;
      if (mc[d] < C[d] - 1) mc[d]++;
      else if (mr[d] < R[d] - 1) begin mr[d]++; mc[d] = 0; end
      else nxt = 1;
    end else if (ch == 8'h0A) begin
      if (mr[d] < R[d] - 1) begin mr[d]++; mc[d] = 0; upd = 1; end
      else nxt = 1;
    end else if (ch == 8'h08) begin
      if (mc[d] > 0) begin mc[d]--; mg[d][mr[d]][mc[d]] = 8'h20; upd = 1; end
      else if (mr[d] > 0) begin
        mr[d]--; mc[d] = C[d] - 1; mg[d][mr[d]][mc[d]] = 8'h20; upd = 1;
      end
    end else if (ch == 8'h0C) begin
      nxt = 2;
    end
  endtask

  // Grid read out row by row, left to right, first character ending up most significant.
  function automatic logic [639:0] exp_rows(input int d);
    logic [639:0] v = '0;
    for (int r = 0; r < R[d]; r++)
      for (int c = 0; c < C[d]; c++)
        v = (v << 8) | 640'(mg[d][r][c]);
    return v;
  endfunction

  task automatic check_all(input int d, input string tag, input int eu, input int eb, input int ed);
    sample(d);
    chk({tag, "/rows"},    o_rows,           exp_rows(d));
    chk({tag, "/cur_row"}, 640'(o_row),      640'(mr[d]));
    chk({tag, "/cur_col"}, 640'(o_col),      640'(mc[d]));
    chk({tag, "/busy"},    640'(o_busy),     640'(eb));
    chk({tag, "/update"},  640'(o_upd),      640'(eu));
    chk({tag, "/drop"},    640'(o_drop),     640'(ed));
  endtask

  // One request; inj != 0 injects an 'X' strobe while busy (before busy edge number inj).
  task automatic req(input int d, input logic [7:0] ch, input int inj);
    int upd, nxt, n, ups;
    @(negedge clk); drive(d, 1'b1, ch);
    @(posedge clk); #1; drive(d, 1'b0, 8'h00);
    model_apply(d, ch, upd, nxt);
    $display("req d%0d msg=%02h cursor=(%0d,%0d) next=%0d", d, ch, mr[d], mc[d], nxt);
    check_all(d, "req", upd, (nxt != 0) ? 1 : 0, 0);
    if (nxt == 1) begin
      if (inj != 0) begin @(negedge clk); drive(d, 1'b1, 8'h58); end
      @(posedge clk); #1; drive(d, 1'b0, 8'h00);
      model_scroll(d);
      check_all(d, "scroll", 1, 0, (inj != 0) ? 1 : 0);
    end else if (nxt == 2) begin
      n = 0;
      ups = 0;
      do begin
        if (inj != 0 && n + 1 == inj) begin @(negedge clk); drive(d, 1'b1, 8'h58); end
        @(posedge clk); #1; drive(d, 1'b0, 8'h00);
        n++;
        sample(d);
        if (o_upd) ups++;
        chk("clear/drop", 640'(o_drop), 640'(n == inj));
      end while (o_busy && n < 200);
      model_clear(d);
      chk("clear/len", 640'(n), 640'(C[d]));
      chk("clear/upd_pulses", 640'(ups), 640'(1));
      check_all(d, "clear", 1, 0, 0);
    end
  endtask

  task automatic req_str(input int d, input string s);
    for (int i = 0; i < s.len(); i++) req(d, s[i], 0);
  endtask

  initial begin
    logic [7:0] ch;
    logic [7:0] others [6] = '{8'h00, 8'h7F, 8'h0D, 8'h1B, 8'h80, 8'hFF};
    int p, inj;

    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    model_clear(0);
    model_clear(1);
    repeat (2) @(posedge clk);
    #1;
    check_all(0, "reset0", 0, 0, 0);
    check_all(1, "reset1", 0, 0, 0);
    @(negedge clk); nRst = 1'b1;

    // Typing, newline, wrap and backspace across the row boundary
    req_str(0, "HANGMAN");
    req(0, 8'h0A, 0);
    req(0, 8'h0C, 0);
    for (int i = 0; i < 16; i++) req(0, 8'h41, 0);
    req(0, 8'h42, 0);
    req(0, 8'h08, 0);
    req(0, 8'h08, 0);

    // Full grid: the 32nd character triggers the scroll
    req(0, 8'h0C, 0);
    for (int i = 0; i < 26; i++) req(0, 8'(8'h41 + i), 0);
    for (int i = 0; i < 6; i++)  req(0, 8'(8'h61 + i), 0);

    // Clear with a strobe on busy cycle 5
    req(0, 8'h0C, 5);

    // Reset in the middle of a clear
    req_str(0, "RST");
    @(negedge clk); drive(0, 1'b1, 8'h0C);
    @(posedge clk); #1; drive(0, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk); nRst = 1'b0;
    #1;
    model_clear(0);
    model_clear(1);
    check_all(0, "async_reset", 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); nRst = 1'b1;
    #1;
    check_all(0, "post_reset0", 0, 0, 0);
    check_all(1, "post_reset1", 0, 0, 0);

    // 4x20 instance: origin backspace, ignored code, newline scroll at the bottom row
    req(1, 8'h08, 0);
    req(1, 8'h7F, 0);
    req_str(1, "TOP");
    for (int i = 0; i < 3; i++) req(1, 8'h0A, 0);
    req_str(1, "END");
    req(1, 8'h0A, 0);
    req(1, 8'h08, 0);

    // Random traffic on both instances
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 250; i++) begin
        p = $urandom_range(0, 99);
        if (p < 65)      ch = 8'($urandom_range(32, 126));
        else if (p < 75) ch = 8'h0A;
        else if (p < 88) ch = 8'h08;
        else if (p < 91) ch = 8'h0C;
        else             ch = others[$urandom_range(0, 5)];
        inj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, C[d]) : 0;
        req(d, ch, inj);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
